// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: FSM states, defaults, fetch range check.
// Imported by fetch_stage and if_id_reg.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_IMEM_WORDS = 32'h0000_0200;
    localparam logic [31:0] DEFAULT_NOP_INSTR  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

    // Limit is widened to 34 bits so a large window cannot overflow.
    function automatic logic pc_illegal(
        input logic [31:0] pc,
        input logic [31:0] words
    );
        logic [33:0] limit;
        limit = {words, 2'b00};
        return (pc[1:0] != 2'b00) ||
               ({2'b00, pc} >= limit);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clr loads a bubble, en loads data with valid=1,
// neither holds. Ports: clk, reset, en, clr, instr_nxt, pc_plus4_nxt -> instr, pc_plus4, valid.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] instr_nxt,
    input  logic [31:0] pc_plus4_nxt,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            instr    <= NOP;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else if (en) begin
            instr    <= instr_nxt;
            pc_plus4 <= pc_plus4_nxt;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, next-PC mux, fetch range check, BOOT/RUN/HALT FSM, counters.
// Ports: imem_addr/imem_rdata to memory, stall/flush/redirect in, IF/ID + fault + counters out.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] IMEM_WORDS = DEFAULT_IMEM_WORDS,
    parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_d,
    input  logic [31:0] branch_tgt_d,
    input  logic        jump_d,
    input  logic [31:0] jump_tgt_d,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    fetch_state_e state;

    logic        in_run;
    logic        pc_bad;
    logic        fault_edge;
    logic        active;
    logic        ifid_en;
    logic        ifid_clr;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    if_id_t      ifid_nxt;

    assign imem_addr = pc_f;
    assign pc_plus4  = pc_f + 32'd4;

    assign in_run     = (state == ST_RUN);
    assign pc_bad     = pc_illegal(pc_f, IMEM_WORDS);
    // A stalled illegal PC is never fetched, so it cannot fault yet.
    assign fault_edge = in_run && !stall_f && pc_bad;
    assign active     = in_run && !fault_edge;

    // stall_d holds (no en, no clr) and therefore wins over flush_d.
    assign ifid_clr = !active ||
                      (!stall_d && (flush_d || stall_f));
    assign ifid_en  = active && !stall_d &&
                      !flush_d && !stall_f;

    assign ifid_nxt.instr    = imem_rdata;
    assign ifid_nxt.pc_plus4 = pc_plus4;

    always_comb begin
        pc_next = pc_plus4;
        priority case (1'b1)
            stall_f:  pc_next = pc_f;
            jump_d:   pc_next = jump_tgt_d;
            branch_d: pc_next = branch_tgt_d;
            default:  pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else if (active) begin
            pc_f <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_BOOT;
            fault    <= 1'b0;
            fault_pc <= 32'h0;
        end else begin
            unique case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (fault_edge) begin
                        state    <= ST_HALT;
                        fault    <= 1'b1;
                        fault_pc <= pc_f;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (ifid_en)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (in_run && stall_f)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .reset        (reset),
        .en           (ifid_en),
        .clr          (ifid_clr),
        .instr_nxt    (ifid_nxt.instr),
        .pc_plus4_nxt (ifid_nxt.pc_plus4),
        .instr        (instr_d),
        .pc_plus4     (pc_plus4_d),
        .valid        (valid_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the IF stage.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0;
    localparam longint      LIMIT  = 64'd2048;
    localparam logic [31:0] NOP    = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_f, stall_d, flush_d;
    logic        branch_d, jump_d;
    logic [31:0] branch_tgt_d, jump_tgt_d;
    logic [31:0] pc_f, instr_d, pc_plus4_d;
    logic        valid_d, fault;
    logic [31:0] fault_pc, fetch_cnt, stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_p4, m_fpc, m_fc, m_sc;
    logic        m_valid, m_fault, m_booted, m_halted;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .IMEM_WORDS (32'h200),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .branch_d     (branch_d),
        .branch_tgt_d (branch_tgt_d),
        .jump_d       (jump_d),
        .jump_tgt_d   (jump_tgt_d),
        .pc_f         (pc_f),
        .instr_d      (instr_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d),
        .fault        (fault),
        .fault_pc     (fault_pc),
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (longint'(a) < LIMIT)
            return 32'h2008_0001 + (a >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic bad;
        if (reset) begin
            m_pc = RST_PC; m_instr = NOP; m_p4 = 0; m_valid = 0;
            m_fault = 0; m_fpc = 0; m_fc = 0; m_sc = 0;
            m_booted = 0; m_halted = 0;
        end else if (!m_booted) begin
            m_booted = 1;
            m_instr = NOP; m_p4 = 0; m_valid = 0;
        end else if (!m_halted) begin
            bad = (m_pc % 4 != 0) || (longint'(m_pc) >= LIMIT);
            if (!stall_f && bad) begin
                m_halted = 1; m_fault = 1; m_fpc = m_pc;
                m_instr = NOP; m_p4 = 0; m_valid = 0;
            end else begin
                if (stall_f) m_sc = m_sc + 1;
                if (stall_d) begin
                end else if (flush_d || stall_f) begin
                    m_instr = NOP; m_p4 = 0; m_valid = 0;
                end else begin
                    m_instr = mem_word(m_pc);
                    m_p4 = m_pc + 4; m_valid = 1;
                    m_fc = m_fc + 1;
                end
                if (stall_f) ;
                else if (jump_d) m_pc = jump_tgt_d;
                else if (branch_d) m_pc = branch_tgt_d;
                else m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("pc_f", pc_f, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("instr_d", instr_d, m_instr);
        check("pc_plus4_d", pc_plus4_d, m_p4);
        check("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
        check("fault", {31'b0, fault}, {31'b0, m_fault});
        check("fault_pc", fault_pc, m_fpc);
        check("fetch_cnt", fetch_cnt, m_fc);
        check("stall_cnt", stall_cnt, m_sc);
    endtask

    task automatic drive(input logic rs, input logic sf,
                         input logic sd, input logic fl,
                         input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        reset = rs; stall_f = sf; stall_d = sd; flush_d = fl;
        branch_d = br; branch_tgt_d = bt;
        jump_d = jp; jump_tgt_d = jt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        // 1: BOOT then sequential fetch
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("t1_boot_valid", {31'b0, valid_d}, 32'd0);
        idle(3);
        check("t1_fetch_cnt", fetch_cnt, 32'd3);
        check("t1_instr", instr_d, 32'h2008_0003);
        // 2: double stall
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        step();
        step();
        check("t2_stall_cnt", stall_cnt, 32'd2);
        idle(3);
        // 3: branch with flush
        drive(0, 0, 0, 1, 1, 32'h40, 0, 0);
        step();
        check("t3_pc", pc_f, 32'h40);
        check("t3_bubble", {31'b0, valid_d}, 32'd0);
        idle(2);
        // 4: jump beats branch; stall_f beats both
        drive(0, 0, 0, 0, 1, 32'h40, 1, 32'h80);
        step();
        check("t4_jump", pc_f, 32'h80);
        drive(0, 1, 0, 0, 1, 32'h40, 1, 32'h100);
        step();
        check("t4_stall", pc_f, 32'h80);
        idle(2);
        // 5: misaligned then out-of-range
        drive(0, 0, 0, 0, 0, 0, 1, 32'h802);
        step();
        idle(2);
        check("t5_fpc_mis", fault_pc, 32'h802);
        drive(0, 0, 0, 1, 1, 32'h40, 1, 32'h40);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("t5_reset_pc", pc_f, RST_PC);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h800);
        step();
        idle(3);
        check("t5_fpc_oor", fault_pc, 32'h800);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        idle(4);
        // 6: reset mid-stall with flush
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 1, 1, 0, 0, 0, 0);
        step();
        check("t6_cnt", fetch_cnt, 32'd0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom_range(0, 511) << 2;
            jt = $urandom_range(0, 511) << 2;
            if ($urandom_range(0, 99) < 4) jt = jt | 32'h2;
            if ($urandom_range(0, 99) < 4) bt = bt + 32'h800;
            drive(($urandom_range(0, 99) < 2) ||
                  (m_halted && $urandom_range(0, 9) == 0),
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 10, bt,
                  $urandom_range(0, 99) < 8, jt);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
